// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a registered borrow, LSB first.
// The input side uses start/busy and the result side uses valid/ready.
module serial_full_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             diff_valid,
   input  logic             diff_ready
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateType;

   stateType         state;
   stateType         stateNext;
   logic [WIDTH-1:0] aSh;
   logic [WIDTH-1:0] bSh;
   logic             br;
   logic             dBit;
   logic             brNext;
   logic             lastBit;
   logic [CW-1:0]    cnt;

   assign dBit    = aSh[0] ^ bSh[0] ^ br;
   assign brNext  = (~aSh[0] & bSh[0]) | (~(aSh[0] ^ bSh[0]) & br);
   assign lastBit = (cnt == CW'(WIDTH - 1));
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start)      stateNext = SHIFT;
         SHIFT:   if (lastBit)    stateNext = DONE;
         DONE:    if (diff_ready) stateNext = IDLE;
         default:                 stateNext = IDLE;
      endcase
   end

   // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
   always_ff @(posedge clk) begin
      if (rst) begin
         aSh        <= '0;
         bSh        <= '0;
         br         <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         bout       <= 1'b0;
         diff_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  aSh  <= a;
                  bSh  <= b;
                  br   <= bin;
                  cnt  <= '0;
                  diff <= '0;
               end
            end
            SHIFT: begin
               diff <= {dBit, diff[WIDTH-1:1]};
               aSh  <= aSh >> 1;
               bSh  <= bSh >> 1;
               br   <= brNext;
               cnt  <= cnt + 1'b1;
               if (lastBit) begin
                  bout       <= brNext;
                  diff_valid <= 1'b1;
               end
            end
            DONE: begin
               if (diff_ready) begin
                  diff_valid <= 1'b0;
               end
            end
            default: begin
               diff_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Self-checking bench for serial_full_subtractor: directed and random cases at WIDTH=8,
// plus an exhaustive sweep at WIDTH=4 against an arithmetic reference.
module tb_serial_full_subtractor;

   localparam int W8 = 8;
   localparam int W4 = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W8-1:0] a;
   logic [W8-1:0] b;
   logic          bin;
   logic          busy;
   logic [W8-1:0] diff;
   logic          bout;
   logic          diff_valid;
   logic          diff_ready;

   logic          start4;
   logic [W4-1:0] a4;
   logic [W4-1:0] b4;
   logic          bin4;
   logic          busy4;
   logic [W4-1:0] diff4;
   logic          bout4;
   logic          valid4;
   logic          ready4;

   int   checkCount = 0;
   int   passCount  = 0;
   int   failCount  = 0;
   int   lat;
   logic busyHeld;

   always #5 clk = ~clk;

   serial_full_subtractor #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .diff(diff), .bout(bout),
      .diff_valid(diff_valid), .diff_ready(diff_ready)
   );

   serial_full_subtractor #(.WIDTH(W4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .diff(diff4), .bout(bout4),
      .diff_valid(valid4), .diff_ready(ready4)
   );

   // Reference: plain signed arithmetic; bit 32 is the borrow, low bits the wrapped difference.
   function automatic logic [32:0] refSub(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic c);
      longint r;
      longint m;
      logic [32:0] res;
      r = longint'(x) - longint'(y) - longint'(c);
      m = (longint'(1) << w) - 1;
      res[32]   = (r < 0);
      res[31:0] = 32'(r & m);
      return res;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic waitValid();
      lat      = 0;
      busyHeld = busy;
      while (!diff_valid && lat < 3 * W8) begin
         @(negedge clk);
         lat++;
         busyHeld &= busy;
      end
   endtask

   // Pulses start for one edge, then scrambles the operands to prove they were captured.
   task automatic applyStimulus(input logic [W8-1:0] ta, input logic [W8-1:0] tb, input logic tbin);
      @(negedge clk);
      a = ta; b = tb; bin = tbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      waitValid();
   endtask

   task automatic checkOutput(input string tag, input logic [W8-1:0] ta, input logic [W8-1:0] tb,
                              input logic tbin);
      logic [32:0] r;
      r = refSub(W8, 32'(ta), 32'(tb), tbin);
      check({tag, ".latency"}, 32'(lat), 32'(W8));
      check({tag, ".valid"}, 32'(diff_valid), 32'd1);
      check({tag, ".busy"}, 32'(busyHeld), 32'd1);
      check({tag, ".diff"}, 32'(diff), {24'd0, r[7:0]});
      check({tag, ".bout"}, 32'(bout), {31'd0, r[32]});
   endtask

   task automatic releaseResult(input string tag);
      diff_ready = 1'b1;
      @(negedge clk);
      diff_ready = 1'b0;
      check({tag, ".validDrop"}, 32'(diff_valid), 32'd0);
      check({tag, ".idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [W8-1:0] holdDiff;
      logic          holdBout;
      logic [32:0]   r4;
      int            l4;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0; diff_ready = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0; ready4 = 1'b1;
      repeat (2) @(negedge clk);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.valid", 32'(diff_valid), 32'd0);
      check("reset.diff", 32'(diff), 32'd0);
      check("reset.bout", 32'(bout), 32'd0);
      rst = 1'b0;

      applyStimulus(8'd5, 8'd3, 1'b0);
      checkOutput("t5m3", 8'd5, 8'd3, 1'b0);
      releaseResult("t5m3");

      // Backpressure: the result must hold still while the consumer stalls.
      applyStimulus(8'd3, 8'd5, 1'b0);
      checkOutput("t3m5", 8'd3, 8'd5, 1'b0);
      holdDiff = diff;
      holdBout = bout;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall.valid", 32'(diff_valid), 32'd1);
         check("stall.diff", 32'(diff), 32'(holdDiff));
         check("stall.bout", 32'(bout), 32'(holdBout));
      end
      releaseResult("stall");
      check("stall.diffKept", 32'(diff), 32'd254);

      applyStimulus(8'd0, 8'd0, 1'b1);
      checkOutput("t0m0b1", 8'd0, 8'd0, 1'b1);
      releaseResult("t0m0b1");

      // Reset hits on the 4th shift edge; bout is still 1 from the previous result.
      @(negedge clk);
      a = 8'd200; b = 8'd13; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midRst.busy", 32'(busy), 32'd0);
      check("midRst.valid", 32'(diff_valid), 32'd0);
      check("midRst.diff", 32'(diff), 32'd0);
      check("midRst.bout", 32'(bout), 32'd0);

      applyStimulus(8'd255, 8'd255, 1'b0);
      checkOutput("t255m255", 8'd255, 8'd255, 1'b0);
      releaseResult("t255m255");

      // start held high with operands changing every cycle: only the first set is captured.
      @(negedge clk);
      a = 8'd100; b = 8'd37; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      lat      = 0;
      busyHeld = busy;
      while (!diff_valid && lat < 3 * W8) begin
         a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
         @(negedge clk);
         lat++;
         busyHeld &= busy;
      end
      checkOutput("holdStart", 8'd100, 8'd37, 1'b1);
      diff_ready = 1'b1;
      a = 8'd9; b = 8'd4; bin = 1'b0;
      @(negedge clk);
      diff_ready = 1'b0;
      check("holdStart.notAccepted", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      waitValid();
      checkOutput("holdStart2", 8'd9, 8'd4, 1'b0);
      releaseResult("holdStart2");

      for (int k = 0; k < 20; k++) begin
         logic [W8-1:0] ra;
         logic [W8-1:0] rb;
         logic          rc;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         applyStimulus(ra, rb, rc);
         checkOutput("rand", ra, rb, rc);
         releaseResult("rand");
      end

      // Exhaustive sweep of the narrow instance with the consumer always ready.
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         a4 = 4'(i); b4 = 4'(i >> 4); bin4 = 1'(i >> 8); start4 = 1'b1;
         @(negedge clk);
         start4 = 1'b0;
         l4 = 0;
         while (!valid4 && l4 < 5 * W4) begin
            @(negedge clk);
            l4++;
         end
         r4 = refSub(W4, 32'(i & 15), 32'((i >> 4) & 15), 1'(i >> 8));
         check("ex4.latency", 32'(l4), 32'(W4));
         check("ex4.diff", 32'(diff4), {28'd0, r4[3:0]});
         check("ex4.bout", 32'(bout4), {31'd0, r4[32]});
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
